// File: rtl/mux_src_pkg.sv
// Shared definitions for the mux source bank: default geometry of the
// word bank and the scan FSM state encoding.
package mux_src_pkg;

   localparam int WIDTH = 16;
   localparam int DEPTH = 16;
   localparam int SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scanState_e;

endpackage

// File: rtl/mux_src_scan_fsm.sv
// Select generator for the mux source bank. In IDLE the select can be
// loaded by hand. A start pulse sweeps it from 0 up to a latched end index,
// honouring stall. A single DONE cycle follows, and then the FSM returns to
// IDLE. The select never wraps, and it keeps the end index after a scan.
module mux_src_scan_fsm
   import mux_src_pkg::*;
#(
   parameter int SelW = SEL_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sel_ld,
   input  logic [SelW-1:0] sel_in,
   input  logic            start,
   input  logic [SelW-1:0] scan_end,
   input  logic            stall,
   output logic [SelW-1:0] sel,
   output logic            busy,
   output logic            scan_valid,
   output logic            done
);

   scanState_e      state_q, state_d;
   logic [SelW-1:0] endR_q, endR_d;
   logic [SelW-1:0] sel_q, sel_d;

   // State, latched end index and select; reset can land mid-scan
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         endR_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         endR_q  <= endR_d;
         sel_q   <= sel_d;
      end
   end

   // Next state: start beats sel_ld in IDLE, both ignored outside IDLE
   always_comb begin
      state_d = state_q;
      endR_d  = endR_q;
      sel_d   = sel_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               endR_d  = scan_end;
               sel_d   = '0;
               state_d = SCAN;
            end else if (sel_ld) begin
               sel_d = sel_in;
            end
         end
         SCAN: begin
            if (!stall) begin
               if (sel_q == endR_q) begin
                  state_d = DONE;
               end else begin
                  sel_d = sel_q + SelW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status flags decoded purely from the state register
   always_comb begin
      busy       = 1'b0;
      scan_valid = 1'b0;
      done       = 1'b0;
      case (state_q)
         SCAN: begin
            busy       = 1'b1;
            scan_valid = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign sel = sel_q;

endmodule

// File: rtl/mux_src_bank.sv
// Source stage for a 16:1 word multiplexer. It holds DEPTH programmable
// words, presented flat on q_flat, and it instantiates the scan FSM that
// drives the registered select.
// Optional build macro MUX_SRC_BANK_CLEAR_EN adds a clr input. That input
// zeroes every entry, and it wins over a write in the same cycle.
module mux_src_bank #(
   parameter int WIDTH = mux_src_pkg::WIDTH,
   parameter int DEPTH = mux_src_pkg::DEPTH,
   parameter int SEL_W = mux_src_pkg::SEL_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we,
   input  logic [SEL_W-1:0]   waddr,
   input  logic [WIDTH-1:0]   wdata,
   input  logic               sel_ld,
   input  logic [SEL_W-1:0]   sel_in,
   input  logic               start,
   input  logic [SEL_W-1:0]   scan_end,
   input  logic               stall,
`ifdef MUX_SRC_BANK_CLEAR_EN
   input  logic               clr,
`endif
   output logic [WIDTH*DEPTH-1:0] q_flat,
   output logic [SEL_W-1:0]   sel,
   output logic               busy,
   output logic               scan_valid,
   output logic               done
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   // Next contents of the bank: clear (when built in) beats a write
   always_comb begin
      mem_d = mem_q;
`ifdef MUX_SRC_BANK_CLEAR_EN
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
         end
      end else if (we) begin
         mem_d[waddr] = wdata;
      end
`else
      if (we) begin
         mem_d[waddr] = wdata;
      end
`endif
   end

   // Bank registers, zeroed asynchronously by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Flatten the bank so that entry i lands on mux input a_i
   always_comb begin
      q_flat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         q_flat[WIDTH*i +: WIDTH] = mem_q[i];
      end
   end

   mux_src_scan_fsm #(
      .SelW(SEL_W)
   ) uScanFsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .sel_ld     (sel_ld),
      .sel_in     (sel_in),
      .start      (start),
      .scan_end   (scan_end),
      .stall      (stall),
      .sel        (sel),
      .busy       (busy),
      .scan_valid (scan_valid),
      .done       (done)
   );

endmodule

// File: doc/mux_src_bank.md
Name: mux_src_bank

Overview:
- Upstream source stage for the 16:1, 16-bit word multiplexer.
- Holds 16 programmable 16-bit words that drive the mux data inputs a0..a15.
- Generates the registered 4-bit select, either loaded manually or swept by a scan FSM.
- Downstream logic samples the mux output o whenever scan_valid is high and stall is low.

Parameters:
- WIDTH, 16, bits per entry.
- DEPTH, 16, number of entries (one per mux input).
- SEL_W, 4, select/address width; equals clog2(DEPTH).

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- we  in  1  write enable.
- waddr  in  SEL_W  write entry index.
- wdata  in  WIDTH  write data.
- sel_ld  in  1  load sel_in into sel; honoured only in IDLE.
- sel_in  in  SEL_W  manual select value.
- start  in  1  one-cycle pulse that begins a scan; honoured only in IDLE.
- scan_end  in  SEL_W  last index of the scan; sampled on start.
- stall  in  1  holds sel during SCAN.
- q_flat  out  WIDTH*DEPTH  all entries; entry i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i] and feeds mux input a_i.
- sel  out  SEL_W  registered mux select.
- busy  out  1  high in SCAN and DONE.
- scan_valid  out  1  high in SCAN.
- done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset (rst_n low, asynchronous, also mid-scan): all entries 0, sel 0, FSM in IDLE, busy/scan_valid/done 0. First edge after deassertion behaves as IDLE.
- Write: on the rising edge with we=1, entry[waddr] <= wdata. Visible on q_flat the next cycle (1-cycle latency).
  - Writes are allowed in every state.
  - A write to the currently selected entry changes the mux output one cycle later.
  - No read-bypass.
- Manual select: in IDLE with sel_ld=1, sel <= sel_in on the edge (1-cycle latency).
- FSM states IDLE, SCAN, DONE. Transitions:
  - IDLE, start=1: latch scan_end into end_r, sel <= 0, go to SCAN. start has priority over sel_ld in the same cycle.
  - SCAN, stall=1: hold sel and state.
  - SCAN, stall=0, sel != end_r: sel <= sel+1.
  - SCAN, stall=0, sel == end_r: go to DONE, sel holds end_r.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- In SCAN and DONE, start and sel_ld are ignored (not queued).
- Each index 0..end_r is presented with scan_valid=1 for at least one unstalled cycle. Scan length = end_r+1 unstalled cycles.
- scan_end=0: SCAN lasts one unstalled cycle with sel=0.
- scan_end=15: sweeps 0..15. sel never wraps; increment stops at end_r.
- Changes to scan_end during a scan have no effect.
- All outputs registered or decoded directly from state registers; no combinational input-to-output path.

Optional Feature:
- Macro MUX_SRC_BANK_CLEAR_EN.
- Defined:
  - Adds input port clr (1 bit).
  - clr=1 zeroes all entries on the next edge.
  - clr has priority over a same-cycle write.
  - sel and FSM are unaffected.
- Undefined: no clr port; entries change only by write or reset.

Decomposition:
- Shared package mux_src_pkg:
  - WIDTH/DEPTH/SEL_W defaults.
  - FSM state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2).
- One natural sub-module, mux_src_scan_fsm: owns state, end_r, sel, busy, scan_valid and done.
- Register array and write/clear logic stay in the top.

Test Plan:
- Reset then write: pulse rst_n low, then write entry i = i+1 for i=0..14 and entry 15 = 0 → after reset q_flat=0, sel=0; one cycle after each write the slice reads i+1; mux o on sel=3 reads 0x0004.
- Manual select: sel_ld=1, sel_in=4'hA in IDLE → sel=0xA next cycle; sel_ld during SCAN → sel unchanged.
- Full scan: start, scan_end=15, no stall → scan_valid high 16 cycles with sel 0..15, then done high 1 cycle, busy low after; sel stays 15.
- Stall and short scan: scan_end=2, stall=1 on the 2nd SCAN cycle → sel sequence 0,1,1,2, then done; scan_end=0 → one SCAN cycle with sel=0.
- Reset mid-scan: assert rst_n low while sel=7 → immediately sel=0, busy=0, scan_valid=0, entries 0; a start after release begins a fresh scan.
- With MUX_SRC_BANK_CLEAR_EN: clr and we to entry 5 (0xBEEF) in the same cycle → entry 5 = 0 next cycle; without the macro, elaboration has no clr port.
